// File: rtl/uart_packet_rx.sv
// Packet assembler: frames UART bytes into length-prefixed packets, checks the
// header and hands type + payload to the consumer over a valid/ready handshake.
module uart_packet_rx #(
    parameter int MAX_LEN        = 16,
    parameter int MIN_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_error,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [7:0]                pkt_type,
    output logic [7:0]                pkt_len,
    output logic [(MAX_LEN-4)*8-1:0]  pkt_payload,
    output logic                      ping,
    output logic                      err_short,
    output logic                      err_long,
    output logic                      err_header,
    output logic                      err_frame,
    output logic                      err_timeout,
    output logic                      err_overrun,
    output logic                      busy
);

    localparam int PAY_BYTES = MAX_LEN - 4;
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam int SLOT_W    = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_HOLD,
        S_DISCARD
    } state_t;

    typedef struct packed {
        logic ping;
        logic too_short;
        logic too_long;
        logic header;
        logic frame;
        logic timeout;
        logic overrun;
    } pulses_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         type_q, type_d;
    logic               long_q, long_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    pulses_t            pulse_q, pulse_d;
    logic [7:0]         buf_q [PAY_BYTES];
    logic               clr_buf;
    logic               wr_buf;
    logic [SLOT_W-1:0]  slot;
    logic               in_pkt;
    logic               tmo_hit;

    assign slot    = SLOT_W'(cnt_q - 8'd4);
    assign in_pkt  = state_q inside {S_HEADER, S_PAYLOAD, S_DISCARD};
    // Abort on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    assign tmo_hit = in_pkt && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2));

    // NOTE: every variable is given a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        type_d  = type_q;
        long_d  = long_q;
        tmo_d   = tmo_q;
        pulse_d = '0;
        clr_buf = 1'b0;
        wr_buf  = 1'b0;

        if (rx_valid)
            tmo_d = '0;
        else if (!in_pkt)
            tmo_d = '0;
        else if (tmo_q != '1)
            tmo_d = tmo_q + 1'b1;

        if (in_pkt && rx_error) begin
            pulse_d.frame = 1'b1;
            state_d       = S_IDLE;
        end else if (tmo_hit) begin
            pulse_d.timeout = 1'b1;
            state_d         = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_error) begin
                        pulse_d.frame = 1'b1;
                    end else if (rx_valid) begin
                        if (rx_byte == 8'd0) begin
                            pulse_d.ping = 1'b1;
                        end else if (rx_byte < 8'(MIN_LEN)) begin
                            pulse_d.too_short = 1'b1;
                        end else begin
                            len_d = rx_byte;
                            cnt_d = 8'd1;
                            if (rx_byte <= 8'(MAX_LEN)) begin
                                clr_buf = 1'b1;
                                state_d = S_HEADER;
                            end else begin
                                long_d  = 1'b1;
                                state_d = S_DISCARD;
                            end
                        end
                    end
                end
                S_HEADER: begin
                    if (rx_valid) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'd3) begin
                            type_d  = rx_byte;
                            state_d = S_PAYLOAD;
                        end else if (rx_byte != 8'd0) begin
                            pulse_d.header = 1'b1;
                            long_d         = 1'b0;
                            state_d        = S_DISCARD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        wr_buf = 1'b1;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == len_q - 8'd1)
                            state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rx_error)
                        pulse_d.frame = 1'b1;
                    else if (rx_valid)
                        pulse_d.overrun = 1'b1;
                    if (pkt_ready)
                        state_d = S_IDLE;
                end
                S_DISCARD: begin
                    if (rx_valid) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == len_q - 8'd1) begin
                            pulse_d.too_long = long_q;
                            state_d          = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            type_q  <= '0;
            long_q  <= 1'b0;
            tmo_q   <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            type_q  <= type_d;
            long_q  <= long_d;
            tmo_q   <= tmo_d;
            pulse_q <= pulse_d;
        end
    end

    // NOTE: the payload buffer is reset so unused bytes read as zero even before the first packet.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAY_BYTES; i++)
                buf_q[i] <= '0;
        end else if (clr_buf) begin
            for (int i = 0; i < PAY_BYTES; i++)
                buf_q[i] <= '0;
        end else if (wr_buf) begin
            buf_q[slot] <= rx_byte;
        end
    end

    for (genvar i = 0; i < PAY_BYTES; i++) begin : g_pay
        assign pkt_payload[8*i +: 8] = buf_q[i];
    end

    assign pkt_valid   = (state_q == S_HOLD);
    assign pkt_type    = type_q;
    assign pkt_len     = len_q;
    assign busy        = (state_q != S_IDLE);
    assign ping        = pulse_q.ping;
    assign err_short   = pulse_q.too_short;
    assign err_long    = pulse_q.too_long;
    assign err_header  = pulse_q.header;
    assign err_frame   = pulse_q.frame;
    assign err_timeout = pulse_q.timeout;
    assign err_overrun = pulse_q.overrun;

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- Packet assembler between the byte-level UART receiver and the command/work decoder.
- Frames incoming bytes into length-prefixed packets and checks the header.
- Buffers up to MAX_LEN bytes and presents type + payload to the consumer through a valid/ready handshake.
- Reports ping, short, long, header, framing, timeout and overrun conditions as single-cycle pulses.

Parameters:
- MAX_LEN, 16, largest accepted packet length in bytes, header included; payload buffer is MAX_LEN-4 bytes (12 bytes = 96 bits by default).
- MIN_LEN, 8, smallest valid non-ping packet length.
- TIMEOUT_CYCLES, 12000, idle cycles allowed between bytes of one packet (1 ms at 12 MHz).

Ports:
- sys_clk  in  1  system clock, UART clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- rx_error  in  1  one-cycle strobe: UART framing error.
- pkt_valid  out  1  packet available.
- pkt_ready  in  1  consumer accepts the packet.
- pkt_type  out  8  header byte 3.
- pkt_len  out  8  total packet length, header included.
- pkt_payload  out  (MAX_LEN-4)*8  payload; byte k is at [8k+7:8k], unused bytes are 0.
- ping  out  1  pulse: length-0 packet received.
- err_short  out  1  pulse: length 1..MIN_LEN-1.
- err_long  out  1  pulse: oversize packet fully drained.
- err_header  out  1  pulse: reserved header byte is nonzero.
- err_frame  out  1  pulse: rx_error seen.
- err_timeout  out  1  pulse: inter-byte timeout.
- err_overrun  out  1  pulse: byte dropped while in HOLD.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Packet format: byte0 = len; byte1 = 0x00; byte2 = 0x00; byte3 = type; bytes 4..len-1 = payload.
- Reset (async assert, sync release): state = IDLE; all outputs 0; payload buffer 0; byte counter 0; timeout counter 0.
- All pulses are registered, high for exactly one cycle.
- IDLE, on rx_valid:
  - len = 0: ping pulses the next cycle; stay in IDLE.
  - 0 < len < MIN_LEN: err_short pulses; stay in IDLE. Following bytes are treated as new length bytes.
  - MIN_LEN <= len <= MAX_LEN: latch len; clear payload buffer; cnt = 1; go to HEADER.
  - len > MAX_LEN: latch len; cnt = 1; go to DISCARD.
- HEADER, on rx_valid, cnt increments:
  - cnt = 1 or 2: byte must be 0x00. A nonzero byte pulses err_header and goes to DISCARD; the remaining bytes of the packet are drained.
  - cnt = 3: latch type; go to PAYLOAD.
- PAYLOAD, on rx_valid: write byte to slot cnt-4; cnt increments. When the byte with cnt = len-1 arrives, go to HOLD. pkt_valid rises on the cycle after that last byte is accepted.
- HOLD:
  - pkt_valid = 1; pkt_type, pkt_len, pkt_payload are stable.
  - pkt_valid & pkt_ready at a clock edge: pkt_valid drops next cycle; go to IDLE.
  - Any rx_valid in HOLD, including the handshake cycle, drops the byte and pulses err_overrun.
- DISCARD: consume bytes until cnt = len-1, then go to IDLE. Pulse err_long only if entry was caused by oversize length; no pkt_valid.
- Timeout:
  - Counter clears on every rx_valid.
  - Counts only in HEADER, PAYLOAD and DISCARD.
  - Reaching TIMEOUT_CYCLES-1 aborts: go to IDLE, pulse err_timeout, packet lost. No timeout in HOLD.
- rx_error:
  - In HEADER, PAYLOAD or DISCARD: pulse err_frame, go to IDLE.
  - In IDLE: pulse err_frame, stay in IDLE.
  - In HOLD: pulse err_frame; the held packet is kept.
  - rx_error and rx_valid in the same cycle: rx_error wins and the byte is ignored.
- Counters: cnt is 8-bit and never wraps, since len <= 255. The timeout counter is sized as clog2(TIMEOUT_CYCLES) and saturates.
- Reset mid-packet: the partial packet is discarded and no pulses are emitted.

Test Plan:
- Info request: bytes 08 00 00 00 AA BB CC DD, pkt_ready = 1 → one pkt_valid cycle with pkt_len = 8, pkt_type = 0x00, pkt_payload[31:0] = 0xDDCCBBAA, upper bits 0.
- Max work packet: len 0x10, type 0x02, payload 01..0C, pkt_ready held low for 50 cycles → pkt_valid held all 50 cycles; pkt_payload = 0x0C0B0A090807060504030201; extra byte 0x55 during HOLD → err_overrun pulse, payload unchanged.
- Boundaries:
  - byte 00 → ping pulse.
  - byte 05 → err_short.
  - byte 0x14 plus 19 further bytes → err_long after the 20th byte; busy low next cycle; no pkt_valid.
- Header check: 08 00 7F ... → err_header on the 3rd byte; remaining 5 bytes are drained; the next 08 00 00 01 + 4 bytes is delivered correctly.
- Timeout: 08 00 00 then silence for 12000 cycles → err_timeout at cycle 11999 after the last byte; state is IDLE; a following valid packet is received correctly.
- Framing and reset: rx_error after the 5th byte → err_frame, IDLE; rst_n low for 1 cycle in mid-PAYLOAD → all outputs 0, no pulses, next packet decoded normally.
